// File: rtl/instruction_register_mb.sv
// Multi-beat SAP instruction register: stages W-bus beats MS-first, commits to a holding IR.
// Optional IR_SIGN_EXT_EN: sign-extend the operand onto w_bus_out instead of zero-extending.
module instruction_register_mb #(
  parameter int BUS_W = 8,
  parameter int OPC_W = 4,
  parameter int OPR_W = 4
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                li_n,
  input  logic                ei_n,
  input  logic                abort_n,
  input  logic [BUS_W-1:0]    w_bus,
  output logic [BUS_W-1:0]    w_bus_out,
  output logic [OPC_W-1:0]    op_code,
  output logic [OPR_W-1:0]    operand,
  output logic                fetch_busy,
  output logic [((((OPC_W+OPR_W+BUS_W-1)/BUS_W) > 1) ?
                $clog2((OPC_W+OPR_W+BUS_W-1)/BUS_W) : 1)-1:0] beat_idx,
  output logic                commit_p,
  output logic                ir_valid
);

  localparam int IW     = OPC_W + OPR_W;
  localparam int NBEATS = (IW + BUS_W - 1) / BUS_W;
  localparam int BIW    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int SW     = NBEATS * BUS_W;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t          state;
  logic [SW-1:0]   staging;
  logic [SW-1:0]   nxt;
  logic [IW-1:0]   ir;
  logic [BUS_W-1:0] ext;
  logic            last;

  // staging is all-zero in IDLE, so the first beat lands in the LSBs
  assign nxt  = SW'({staging, w_bus});
  assign last = (NBEATS == 1) ||
                ((state == COLLECT) && (beat_idx == BIW'(NBEATS - 1)));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= IDLE;
      staging  <= '0;
      ir       <= '0;
      beat_idx <= '0;
      commit_p <= 1'b0;
      ir_valid <= 1'b0;
    end else begin
      commit_p <= 1'b0;
      if (!abort_n) begin
        state    <= IDLE;
        staging  <= '0;
        beat_idx <= '0;
      end else if (!li_n) begin
        if (last) begin
          ir       <= IW'(nxt);
          commit_p <= 1'b1;
          ir_valid <= 1'b1;
          staging  <= '0;
          beat_idx <= '0;
          state    <= IDLE;
        end else begin
          staging  <= nxt;
          beat_idx <= beat_idx + 1'b1;
          state    <= COLLECT;
        end
      end
    end
  end

  assign fetch_busy = (state == COLLECT);
  assign op_code    = ir[IW-1:OPR_W];
  assign operand    = ir[OPR_W-1:0];

  generate
    if (OPR_W < BUS_W) begin : g_ext
`ifdef IR_SIGN_EXT_EN
      assign ext = {{(BUS_W-OPR_W){operand[OPR_W-1]}}, operand};
`else
      assign ext = {{(BUS_W-OPR_W){1'b0}}, operand};
`endif
    end else begin : g_noext
      assign ext = operand;
    end
  endgenerate

  assign w_bus_out = ei_n ? {BUS_W{1'bz}} : ext;

endmodule

// File: doc/instruction_register_mb.md
Name: instruction_register_mb

Overview:
Parametrised multi-beat instruction register for the SAP-style datapath. It assembles one instruction from one or more W-bus beats into a staging register. On the final beat it commits the instruction to a holding IR, so op_code and operand stay stable while the next instruction is being fetched. It drives the operand back onto the W bus through a tri-state output under ei_n, as the controller/sequencer expects.

Parameters:
BUS_W, 8, W-bus width in bits
OPC_W, 4, opcode field width
OPR_W, 4, operand field width; must satisfy 1 <= OPR_W <= BUS_W
NBEATS, derived = ceil((OPC_W+OPR_W)/BUS_W), bus beats per instruction; not overridable
IW, derived = OPC_W+OPR_W, committed instruction width

Ports:
clk  in  1  system clock, rising edge
clr_n  in  1  asynchronous active-low reset
li_n  in  1  active-low load: capture w_bus as the next beat on this edge
ei_n  in  1  active-low enable: drive extended operand onto w_bus_out
abort_n  in  1  synchronous active-low: discard a partially assembled instruction
w_bus  in  BUS_W  W-bus data in
w_bus_out  out  BUS_W  operand onto W bus; all bits Z when ei_n=1
op_code  out  OPC_W  committed IR[IW-1:OPR_W]
operand  out  OPR_W  committed IR[OPR_W-1:0]
fetch_busy  out  1  high while 1..NBEATS-1 beats are held in staging
beat_idx  out  max(1,clog2(NBEATS))  number of beats captured for the current instruction
commit_p  out  1  one-cycle pulse in the cycle after the final beat is captured
ir_valid  out  1  high once at least one instruction has been committed since reset

Behaviour:
- Reset (clr_n=0, asynchronous): IR=0, staging=0, beat_idx=0, fetch_busy=0, commit_p=0, ir_valid=0. Hence op_code=0 and operand=0. w_bus_out follows ei_n (Z or 0).
- FSM states:
  - IDLE: beat_idx=0.
  - COLLECT: beat_idx in 1..NBEATS-1.
  - fetch_busy = (state == COLLECT).
- Edge with li_n=0 in IDLE:
  - NBEATS=1: IR <= w_bus[IW-1:0]; commit; stay in IDLE.
  - NBEATS>1: staging <= w_bus; beat_idx <= 1; go to COLLECT.
- Edge with li_n=0 in COLLECT:
  - Beat order is most-significant first: staging <= {staging, w_bus}, i.e. shift left by BUS_W and insert the new beat in the LSBs.
  - If beat_idx = NBEATS-1: IR <= {staging, w_bus}[IW-1:0]; commit; beat_idx <= 0; go to IDLE.
  - Otherwise beat_idx increments.
- Commit: commit_p=1 for exactly one cycle after the committing edge; ir_valid <= 1 and stays set until reset.
- IR changes only on commit. op_code and operand hold their value throughout a subsequent partial fetch.
- li_n=1: no state change; commit_p returns to 0.
- abort_n=0 at an edge: staging <= 0, beat_idx <= 0, go to IDLE. IR, ir_valid and commit_p are unaffected.
  - abort_n=0 together with li_n=0: abort wins and the beat is dropped.
  - abort_n=0 on what would have been the final beat: no commit occurs.
- w_bus_out (combinational) = ei_n=0 ? operand zero-extended to BUS_W : all Z.
- ei_n and li_n asserted in the same cycle is legal. w_bus_out reflects the pre-edge IR; the load takes effect at the edge.
- With the default parameters (8/4/4), the block is cycle-equivalent to a single-beat IR, apart from the asynchronous reset and the added status outputs.
- Reset asserted mid-fetch: all state clears immediately, with no clock needed.

Optional Feature:
Macro IR_SIGN_EXT_EN.
- Defined: w_bus_out = ei_n=0 ? operand sign-extended to BUS_W (operand[OPR_W-1] replicated) : Z. This supports relative-address and immediate-offset instructions.
- Undefined: zero extension as specified above.
- In both cases extension has no effect when OPR_W = BUS_W. Internal state is identical either way.

Test Plan:
- Defaults (8/4/4): reset, then li_n=0 with w_bus=8'hA7 for one edge -> next cycle op_code=4'hA, operand=4'h7, commit_p=1 for one cycle, ir_valid=1; with ei_n=0, w_bus_out=8'h07; with ei_n=1, w_bus_out=Z.
- 8/8/8 (NBEATS=2): beats 8'h3C then 8'h55 -> after beat 1: fetch_busy=1, beat_idx=1, op_code still 0; after beat 2: op_code=8'h3C, operand=8'h55, commit_p pulse, fetch_busy=0.
- 8/8/8: commit 8'h12,8'h34; then load beat 8'hFF and assert abort_n=0 -> op_code=8'h12 and operand=8'h34 retained, beat_idx=0; then beats 8'h56,8'h78 -> IR=16'h5678.
- 8/8/8: li_n=0 and abort_n=0 simultaneously in COLLECT -> no commit, state IDLE, IR unchanged.
- Defaults: load 8'hAF, pulse clr_n=0 between clock edges -> op_code and operand go to 0 immediately and ir_valid=0 without a clock edge.
- 8/4/4 with IR_SIGN_EXT_EN defined: IR=8'h2C, ei_n=0 -> w_bus_out=8'hFC; without the macro, w_bus_out=8'h0C.
